// File: rtl/irrigation_zone_scheduler.sv
// Multi-zone irrigation scheduler: debounced tank levels, round-robin dry-zone scan,
// valve settle then timed sprinkler/dripper run. Optional ALARM_BLINK_EN blinks the low-water alarm.
module irrigation_zone_scheduler #(
    parameter int ZONES          = 4,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int SETTLE_TICKS   = 2,
    parameter int IRRIGATE_TICKS = 8,
    localparam int PW            = (ZONES > 2) ? $clog2(ZONES) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             low_water_level,
    input  logic             mid_water_level,
    input  logic             high_water_level,
    input  logic [ZONES-1:0] earth_humidity,
    input  logic             air_humidity,
    input  logic             low_temperature,
    output logic             conflicting_values,
    output logic             water_supply_valvule,
    output logic [ZONES-1:0] zone_valvule,
    output logic             splinker_bomb,
    output logic             dripper_valvule,
    output logic             alarm,
    output logic [PW-1:0]    active_zone,
    output logic [2:0]       fsm_state
);

    localparam int TMAX = (SETTLE_TICKS > IRRIGATE_TICKS) ? SETTLE_TICKS : IRRIGATE_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int SCW  = $clog2(ZONES + 1);
    localparam int DCW  = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_IRRIGATE = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    // Level vectors are ordered {high, mid, low}
    logic [2:0]          lvl_raw;
    logic [2:0]          lvl_q, lvl_d;
    logic [2:0][DCW-1:0] deb_q, deb_d;
    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d, ptr_next;
    logic [SCW-1:0]      scan_q, scan_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                mode_q, mode_d;
    logic                conflict;
    logic                zone_dry;
    logic                valve_on;

    always_comb begin
        lvl_raw = {high_water_level, mid_water_level, low_water_level};
        lvl_d   = lvl_q;
        deb_d   = deb_q;
        if (tick) begin
            for (int i = 0; i < 3; i++) begin
                if (lvl_raw[i] == lvl_q[i]) begin
                    deb_d[i] = '0;
                end else begin
                    deb_d[i] = deb_q[i] + DCW'(1);
                    if (deb_d[i] == DCW'(DEBOUNCE_TICKS)) begin
                        lvl_d[i] = lvl_raw[i];
                        deb_d[i] = '0;
                    end
                end
            end
        end
    end

    always_comb begin
        conflict = (lvl_q[2] & ~lvl_q[1]) | (lvl_q[1] & ~lvl_q[0]);
        zone_dry = ~earth_humidity[ptr_q];
        ptr_next = (ptr_q == PW'(ZONES - 1)) ? '0 : ptr_q + PW'(1);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        scan_d  = scan_q;
        timer_d = timer_q;
        mode_d  = mode_q;
        if (tick) begin
            // A sensor conflict overrides every state, including an active run
            if (conflict) begin
                state_d = ST_FAULT;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        scan_d  = '0;
                        state_d = ST_SCAN;
                    end
                    ST_SCAN: begin
                        if (zone_dry && lvl_q[0]) begin
                            state_d = ST_SETTLE;
                            timer_d = TW'(SETTLE_TICKS - 1);
                        end else begin
                            ptr_d  = ptr_next;
                            scan_d = scan_q + SCW'(1);
                            if (scan_d == SCW'(ZONES)) state_d = ST_IDLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (timer_q == '0) begin
                            state_d = ST_IRRIGATE;
                            timer_d = TW'(IRRIGATE_TICKS - 1);
                            mode_d  = lvl_q[1] & ~air_humidity & ~low_temperature;
                        end else begin
                            timer_d = timer_q - TW'(1);
                        end
                    end
                    ST_IRRIGATE: begin
                        if ((timer_q == '0) || !zone_dry || !lvl_q[0]) begin
                            ptr_d   = ptr_next;
                            scan_d  = '0;
                            state_d = ST_SCAN;
                        end else begin
                            timer_d = timer_q - TW'(1);
                        end
                    end
                    ST_FAULT: state_d = ST_IDLE;
                    default:  state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lvl_q   <= '0;
            deb_q   <= '0;
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            scan_q  <= '0;
            timer_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            lvl_q   <= lvl_d;
            deb_q   <= deb_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            scan_q  <= scan_d;
            timer_q <= timer_d;
            mode_q  <= mode_d;
        end
    end

`ifdef ALARM_BLINK_EN
    logic blink_q, blink_d;

    always_comb begin
        blink_d = tick ? ~blink_q : blink_q;
    end

    always_ff @(posedge clock) begin
        if (reset) blink_q <= 1'b0;
        else       blink_q <= blink_d;
    end

    always_comb begin
        alarm = conflict | (~lvl_q[1] & blink_q);
    end
`else
    always_comb begin
        alarm = conflict | ~lvl_q[1];
    end
`endif

    // Every actuator is a decode of registered state only
    always_comb begin
        valve_on             = (state_q == ST_SETTLE) || (state_q == ST_IRRIGATE);
        zone_valvule         = valve_on ? (ZONES'(1) << ptr_q) : '0;
        splinker_bomb        = (state_q == ST_IRRIGATE) & mode_q;
        dripper_valvule      = (state_q == ST_IRRIGATE) & ~mode_q;
        conflicting_values   = conflict;
        water_supply_valvule = ~conflict & ~lvl_q[2];
        active_zone          = ptr_q;
        fsm_state            = state_q;
    end

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Table-driven bench for irrigation_zone_scheduler with an expected-output queue.
module tb_irrigation_zone_scheduler;

    logic       clock = 1'b0;
    logic       reset, tick;
    logic       low_water_level, mid_water_level, high_water_level;
    logic [3:0] earth_humidity;
    logic       air_humidity, low_temperature;
    logic       conflicting_values, water_supply_valvule;
    logic [3:0] zone_valvule;
    logic       splinker_bomb, dripper_valvule, alarm;
    logic [1:0] active_zone;
    logic [2:0] fsm_state;

    always #5 clock = ~clock;

    irrigation_zone_scheduler #(
        .ZONES(4), .DEBOUNCE_TICKS(4), .SETTLE_TICKS(2), .IRRIGATE_TICKS(8)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick),
        .low_water_level(low_water_level), .mid_water_level(mid_water_level),
        .high_water_level(high_water_level), .earth_humidity(earth_humidity),
        .air_humidity(air_humidity), .low_temperature(low_temperature),
        .conflicting_values(conflicting_values), .water_supply_valvule(water_supply_valvule),
        .zone_valvule(zone_valvule), .splinker_bomb(splinker_bomb),
        .dripper_valvule(dripper_valvule), .alarm(alarm),
        .active_zone(active_zone), .fsm_state(fsm_state)
    );

    // {conflict, supply, steady alarm}
    localparam logic [2:0] A = 3'b011;  // filtered 000
    localparam logic [2:0] B = 3'b000;  // filtered 111
    localparam logic [2:0] C = 3'b101;  // conflicting levels
    localparam logic [3:0] W = 4'b1111;
    localparam logic [3:0] D = 4'b1011;
    localparam logic [3:0] Z0 = 4'b0000;
    localparam logic [3:0] Z2 = 4'b0100;

    typedef struct {
        logic       rst, tk;
        logic [2:0] lvl;
        logic [3:0] earth;
        logic       air, temp;
        logic [2:0] flags;
        logic [3:0] zone;
        logic       spr, drp;
        logic [2:0] st;
        logic [1:0] ptr;
    } vec_t;

    vec_t        vecs[$];
    logic [13:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        blink_m = 1'b0;

    function automatic vec_t mk(input logic rst, input logic tk, input logic [2:0] lvl,
                                input logic [3:0] earth, input logic air, input logic temp,
                                input logic [2:0] flags, input logic [3:0] zone,
                                input logic spr, input logic drp,
                                input logic [2:0] st, input logic [1:0] ptr);
        vec_t v;
        v.rst = rst; v.tk = tk; v.lvl = lvl; v.earth = earth; v.air = air; v.temp = temp;
        v.flags = flags; v.zone = zone; v.spr = spr; v.drp = drp; v.st = st; v.ptr = ptr;
        return v;
    endfunction

    task automatic step(input string name, input int idx, input vec_t v);
        logic [13:0] act, expv;
        logic        alm_e;
        reset = v.rst; tick = v.tk;
        high_water_level = v.lvl[2]; mid_water_level = v.lvl[1]; low_water_level = v.lvl[0];
        earth_humidity = v.earth; air_humidity = v.air; low_temperature = v.temp;
        if (v.rst) blink_m = 1'b0;
        else if (v.tk) blink_m = ~blink_m;
        alm_e = v.flags[0];
`ifdef ALARM_BLINK_EN
        alm_e = v.flags[2] | (v.flags[0] & ~v.flags[2] & blink_m);
`endif
        exp_q.push_back({v.flags[2:1], alm_e, v.zone, v.spr, v.drp, v.st, v.ptr});
        @(posedge clock);
        @(negedge clock);
        act = {conflicting_values, water_supply_valvule, alarm, zone_valvule,
               splinker_bomb, dripper_valvule, fsm_state, active_zone};
        expv = exp_q.pop_front();
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s[%0d] outputs {conf,sup,alm,zone,spr,drp,st,ptr}: got %b required %b",
                     name, idx, act, expv);
        end
        checks++;
        if (!$onehot0(zone_valvule) || (splinker_bomb && dripper_valvule)) begin
            errors++;
            $display("FAIL %s[%0d] exclusivity: zone=%b spr=%b drp=%b required onehot0 and not both",
                     name, idx, zone_valvule, splinker_bomb, dripper_valvule);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; tick = 1'b0;
        low_water_level = 1'b0; mid_water_level = 1'b0; high_water_level = 1'b0;
        earth_humidity = W; air_humidity = 1'b0; low_temperature = 1'b0;

        // Reset, debounce and an all-wet scan pass
        vecs.push_back(mk(1,0,3'b000,W,0,0,A,Z0,0,0,0,0));
        vecs.push_back(mk(0,1,3'b111,W,0,0,A,Z0,0,0,1,0));
        vecs.push_back(mk(0,1,3'b111,W,0,0,A,Z0,0,0,1,1));
        vecs.push_back(mk(0,1,3'b111,W,0,0,A,Z0,0,0,1,2));
        vecs.push_back(mk(0,1,3'b111,W,0,0,B,Z0,0,0,1,3));
        vecs.push_back(mk(0,1,3'b111,W,0,0,B,Z0,0,0,0,0));
        vecs.push_back(mk(0,1,3'b111,W,0,0,B,Z0,0,0,1,0));
        vecs.push_back(mk(0,0,3'b111,D,0,0,B,Z0,0,0,1,0));
        // Zone 2 dry: settle, then 8-tick sprinkler run
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z0,0,0,1,1));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z0,0,0,1,2));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z2,0,0,2,2));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z2,0,0,2,2));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z2,1,0,3,2));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z0,0,0,1,3));
        // Cold: dripper run, mode held when temp clears, zone goes wet early
        vecs.push_back(mk(0,1,3'b111,D,0,1,B,Z0,0,0,1,0));
        vecs.push_back(mk(0,1,3'b111,D,0,1,B,Z0,0,0,1,1));
        vecs.push_back(mk(0,1,3'b111,D,0,1,B,Z0,0,0,1,2));
        vecs.push_back(mk(0,1,3'b111,D,0,1,B,Z2,0,0,2,2));
        vecs.push_back(mk(0,1,3'b111,D,0,1,B,Z2,0,0,2,2));
        vecs.push_back(mk(0,1,3'b111,D,0,1,B,Z2,0,1,3,2));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z2,0,1,3,2));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z2,0,1,3,2));
        vecs.push_back(mk(0,1,3'b111,W,0,0,B,Z0,0,0,1,3));
        // Conflict during a run, recovery with retained pointer
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z0,0,0,1,0));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z0,0,0,1,1));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z0,0,0,1,2));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z2,0,0,2,2));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z2,0,0,2,2));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z2,1,0,3,2));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,3'b101,D,0,0,B,Z2,1,0,3,2));
        vecs.push_back(mk(0,1,3'b101,D,0,0,C,Z2,1,0,3,2));
        vecs.push_back(mk(0,1,3'b101,D,0,0,C,Z0,0,0,4,2));
        vecs.push_back(mk(0,1,3'b101,D,0,0,C,Z0,0,0,4,2));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,3'b111,D,0,0,C,Z0,0,0,4,2));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z0,0,0,4,2));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z0,0,0,0,2));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z0,0,0,1,2));
        vecs.push_back(mk(0,1,3'b111,D,0,0,B,Z2,0,0,2,2));
        // Reset mid-settle without tick
        vecs.push_back(mk(1,0,3'b111,D,0,0,A,Z0,0,0,0,0));

        @(negedge clock);
        for (int i = 0; i < vecs.size(); i++) step("table", i, vecs[i]);

        // Interrupted debounce restarts the count; then mid&~low conflict faults from SCAN
        step("debounce", 1,  mk(0,1,3'b111,W,0,0,A,Z0,0,0,1,0));
        step("debounce", 2,  mk(0,1,3'b111,W,0,0,A,Z0,0,0,1,1));
        step("debounce", 3,  mk(0,1,3'b111,W,0,0,A,Z0,0,0,1,2));
        step("debounce", 4,  mk(0,1,3'b000,W,0,0,A,Z0,0,0,1,3));
        step("debounce", 5,  mk(0,1,3'b111,W,0,0,A,Z0,0,0,0,0));
        step("debounce", 6,  mk(0,1,3'b111,W,0,0,A,Z0,0,0,1,0));
        step("debounce", 7,  mk(0,1,3'b111,W,0,0,A,Z0,0,0,1,1));
        step("debounce", 8,  mk(0,1,3'b111,W,0,0,B,Z0,0,0,1,2));
        step("lowconf",  9,  mk(0,1,3'b110,W,0,0,B,Z0,0,0,1,3));
        step("lowconf",  10, mk(0,1,3'b110,W,0,0,B,Z0,0,0,0,0));
        step("lowconf",  11, mk(0,1,3'b110,W,0,0,B,Z0,0,0,1,0));
        step("lowconf",  12, mk(0,1,3'b110,W,0,0,C,Z0,0,0,1,1));
        step("lowconf",  13, mk(0,1,3'b110,W,0,0,C,Z0,0,0,4,1));

        tick = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
